// File: rtl/jtag_scan_arbiter.sv
// Round-robin arbiter that shares one JTAG master between two requesters: captures the winner's
// IR/DR, loads the master FIFOs, kicks each scan and watches busy with rise and scan timeouts.
//
// state      | meaning
// ST_IDLE    | waiting for a request; round-robin grant
// ST_LOAD_IR | push captured IR into the instruction FIFO once not full
// ST_START   | issue work with op/len for the current phase
// ST_WAIT_HI | wait for busy to rise (BUSY_RISE_MAX bound)
// ST_WAIT_LO | wait for busy to fall (SCAN_TIMEOUT bound)
// ST_DRAIN   | scan timed out; wait for the master to go idle
// ST_LOAD_DR | push captured DR into the data FIFO once not full
// ST_DONE    | done pulse is out; return to idle
module jtag_scan_arbiter #(
  parameter int DATA_INSTRUCTION = 10,
  parameter int DATA_FIFO        = 8,
  parameter int BUSY_RISE_MAX    = 8,
  parameter int SCAN_TIMEOUT     = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0,
  input  logic [DATA_INSTRUCTION-1:0] ir0,
  input  logic [DATA_FIFO-1:0]        dr0,
  input  logic                        dr_en0,
  output logic                        gnt0,
  output logic                        done0,
  output logic                        err0,
  input  logic                        req1,
  input  logic [DATA_INSTRUCTION-1:0] ir1,
  input  logic [DATA_FIFO-1:0]        dr1,
  input  logic                        dr_en1,
  output logic                        gnt1,
  output logic                        done1,
  output logic                        err1,
  output logic                        work,
  output logic                        op,
  output logic [15:0]                 len,
  input  logic                        busy,
  output logic [DATA_INSTRUCTION-1:0] wdata_instruction,
  output logic                        wr_instruction,
  input  logic                        full_instruction,
  output logic [DATA_FIFO-1:0]        wdata_data,
  output logic                        wr_data,
  input  logic                        full_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_IR, ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_DRAIN, ST_LOAD_DR, ST_DONE
  } state_t;

  localparam logic [15:0] LEN_IR    = 16'(DATA_INSTRUCTION);
  localparam logic [15:0] LEN_DR    = 16'(DATA_FIFO);
  localparam logic [15:0] RISE_LAST = 16'(BUSY_RISE_MAX - 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_TIMEOUT - 1);

  state_t                      state_q, state_d;
  logic                        last_q, last_d;
  logic                        owner_q, owner_d;
  logic                        phase_q, phase_d;
  logic [DATA_INSTRUCTION-1:0] ir_q, ir_d;
  logic [DATA_FIFO-1:0]        dr_q, dr_d;
  logic                        dr_en_q, dr_en_d;
  logic [15:0]                 timer_q, timer_d;

  logic                        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                        done0_q, done0_d, done1_q, done1_d;
  logic                        err0_q, err0_d, err1_q, err1_d;
  logic                        work_q, work_d;
  logic                        op_q, op_d;
  logic [15:0]                 len_q, len_d;
  logic [DATA_INSTRUCTION-1:0] wdi_q, wdi_d;
  logic                        wri_q, wri_d;
  logic [DATA_FIFO-1:0]        wdd_q, wdd_d;
  logic                        wrd_q, wrd_d;

  logic                        winner;
  logic                        done_p, err_p;

  // With both requests up the side that did not win last time gets the grant.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    phase_d = phase_q;
    ir_d    = ir_q;
    dr_d    = dr_q;
    dr_en_d = dr_en_q;
    timer_d = (&timer_q) ? timer_q : timer_q + 16'd1;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_p  = 1'b0;
    err_p   = 1'b0;
    work_d  = 1'b0;
    op_d    = op_q;
    len_d   = len_q;
    wdi_d   = wdi_q;
    wri_d   = 1'b0;
    wdd_d   = wdd_q;
    wrd_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          last_d  = winner;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          ir_d    = winner ? ir1 : ir0;
          dr_d    = winner ? dr1 : dr0;
          dr_en_d = winner ? dr_en1 : dr_en0;
          phase_d = 1'b0;
          state_d = ST_LOAD_IR;
        end
      end
      ST_LOAD_IR: begin
        if (!full_instruction) begin
          wri_d   = 1'b1;
          wdi_d   = ir_q;
          state_d = ST_START;
        end
      end
      ST_START: begin
        work_d  = 1'b1;
        op_d    = phase_q;
        len_d   = phase_q ? LEN_DR : LEN_IR;
        timer_d = 16'd0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (busy) begin
          timer_d = 16'd0;
          state_d = ST_WAIT_LO;
        end else if (timer_q == RISE_LAST) begin
          err_p   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        // A falling busy wins over the timeout on the same cycle.
        if (!busy) begin
          if (!phase_q && dr_en_q) begin
            state_d = ST_LOAD_DR;
          end else begin
            done_p  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (timer_q == SCAN_LAST) begin
          err_p   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!busy) state_d = ST_IDLE;
      end
      ST_LOAD_DR: begin
        if (!full_data) begin
          wrd_d   = 1'b1;
          wdd_d   = dr_q;
          phase_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done0_d = done_p & ~owner_q;
    done1_d = done_p & owner_q;
    err0_d  = err_p & ~owner_q;
    err1_d  = err_p & owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      phase_q <= 1'b0;
      ir_q    <= '0;
      dr_q    <= '0;
      dr_en_q <= 1'b0;
      timer_q <= 16'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      work_q  <= 1'b0;
      op_q    <= 1'b0;
      len_q   <= 16'd0;
      wdi_q   <= '0;
      wri_q   <= 1'b0;
      wdd_q   <= '0;
      wrd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      phase_q <= phase_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      dr_en_q <= dr_en_d;
      timer_q <= timer_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      work_q  <= work_d;
      op_q    <= op_d;
      len_q   <= len_d;
      wdi_q   <= wdi_d;
      wri_q   <= wri_d;
      wdd_q   <= wdd_d;
      wrd_q   <= wrd_d;
    end
  end

  assign gnt0              = gnt0_q;
  assign gnt1              = gnt1_q;
  assign done0             = done0_q;
  assign done1             = done1_q;
  assign err0              = err0_q;
  assign err1              = err1_q;
  assign work              = work_q;
  assign op                = op_q;
  assign len               = len_q;
  assign wdata_instruction = wdi_q;
  assign wr_instruction    = wri_q;
  assign wdata_data        = wdd_q;
  assign wr_data           = wrd_q;

endmodule

// File: tb/tb_jtag_scan_arbiter.sv
// Bench for jtag_scan_arbiter: each sequence is planned as a timeline of expected pulses derived
// from the arbitration, FIFO-load and busy handshake rules, then compared cycle by cycle.
module tb_jtag_scan_arbiter;
  localparam int IRW  = 10;
  localparam int DRW  = 8;
  localparam int RISE = 8;
  localparam int TMO  = 4096;

  localparam logic [8:0] B_WRD   = 9'h001;
  localparam logic [8:0] B_WRI   = 9'h002;
  localparam logic [8:0] B_WORK  = 9'h004;
  localparam logic [8:0] B_ERR0  = 9'h008;
  localparam logic [8:0] B_ERR1  = 9'h010;
  localparam logic [8:0] B_DONE0 = 9'h020;
  localparam logic [8:0] B_DONE1 = 9'h040;
  localparam logic [8:0] B_GNT0  = 9'h080;
  localparam logic [8:0] B_GNT1  = 9'h100;

  logic clk = 1'b0;
  logic rst, req0, req1, dr_en0, dr_en1, busy, full_instruction, full_data;
  logic [IRW-1:0] ir0, ir1;
  logic [DRW-1:0] dr0, dr1;
  logic gnt0, done0, err0, gnt1, done1, err1, work, op, wr_instruction, wr_data;
  logic [15:0] len;
  logic [IRW-1:0] wdata_instruction;
  logic [DRW-1:0] wdata_data;

  always #5 clk = ~clk;

  jtag_scan_arbiter #(
    .DATA_INSTRUCTION(IRW), .DATA_FIFO(DRW), .BUSY_RISE_MAX(RISE), .SCAN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .ir0(ir0), .dr0(dr0), .dr_en0(dr_en0), .gnt0(gnt0), .done0(done0), .err0(err0),
    .req1(req1), .ir1(ir1), .dr1(dr1), .dr_en1(dr_en1), .gnt1(gnt1), .done1(done1), .err1(err1),
    .work(work), .op(op), .len(len), .busy(busy),
    .wdata_instruction(wdata_instruction), .wr_instruction(wr_instruction),
    .full_instruction(full_instruction),
    .wdata_data(wdata_data), .wr_data(wr_data), .full_data(full_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int last_w;
  int cur_w;

  // Planned timeline of one sequence, keyed by cycle offset from its grant edge.
  logic [8:0]     ep   [int];
  bit             bz   [int];
  bit             fi   [int];
  bit             fd   [int];
  logic           eop  [int];
  logic [15:0]    elen [int];
  logic [IRW-1:0] ewdi [int];
  logic [DRW-1:0] ewdd [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  function automatic logic [8:0] pulses_now();
    return {gnt1, gnt0, done1, done0, err1, err0, work, wr_instruction, wr_data};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {20'd0, gnt0, gnt1, done0, done1, err0, err1, work, op, len,
            wdata_instruction, wr_instruction, wdata_data, wr_data};
  endfunction

  function automatic void add_p(input int k, input logic [8:0] m);
    if (ep.exists(k)) ep[k] = ep[k] | m;
    else ep[k] = m;
  endfunction

  // One scan phase starting with work at cycle wk; busy rises r cycles later and stays h cycles.
  // r beyond RISE means busy never rises. res: 0 ok, 1 rise timeout, 2 scan timeout.
  function automatic void sched_phase(input int wk, input int r, input int h, input logic opv,
                                      input logic [15:0] lenv, output int res, output int x);
    add_p(wk, B_WORK);
    elen[wk] = lenv;
    eop[wk]  = opv;
    if (r > RISE) begin
      add_p(wk + RISE, cur_w ? B_ERR1 : B_ERR0);
      res = 1;
      x   = wk + RISE;
    end else begin
      x = wk + r + h;
      for (int k = wk; k < x; k++) eop[k] = opv;
      for (int k = 0; k < h; k++) bz[wk + r + k] = 1'b1;
      if (h <= TMO) res = 0;
      else begin
        add_p(wk + r + TMO, cur_w ? B_ERR1 : B_ERR0);
        res = 2;
      end
    end
  endfunction

  task automatic run_seq(input logic [1:0] pat, input bit hold,
                         input logic [IRW-1:0] i0, input logic [IRW-1:0] i1,
                         input logic [DRW-1:0] d0, input logic [DRW-1:0] d1,
                         input bit e0, input bit e1,
                         input int f_ir, input int r1, input int h1,
                         input int f_dr, input int r2, input int h2,
                         input int gap, input int rst_at);
    int wi, wd, x, x2, res, e_end;
    logic [IRW-1:0] irw;
    logic [DRW-1:0] drw;
    bit enw;
    logic [8:0] obs, expv;

    for (int g = 0; g < gap; g++) begin
      req0 = 1'b0; req1 = 1'b0; busy = 1'b0; full_instruction = 1'b0; full_data = 1'b0;
      @(posedge clk); @(negedge clk);
      obs = pulses_now();
      if (obs != 9'd0) chk("idle_pulse", obs, 9'd0);
    end

    ep.delete(); bz.delete(); fi.delete(); fd.delete();
    eop.delete(); elen.delete(); ewdi.delete(); ewdd.delete();

    if (pat == 2'b01) cur_w = 0;
    else if (pat == 2'b10) cur_w = 1;
    else cur_w = (last_w == 1) ? 0 : 1;
    last_w = cur_w;
    irw = cur_w ? i1 : i0;
    drw = cur_w ? d1 : d0;
    enw = cur_w ? e1 : e0;

    add_p(0, cur_w ? B_GNT1 : B_GNT0);
    for (int k = 1; k <= f_ir; k++) fi[k] = 1'b1;
    wi = f_ir + 1;
    add_p(wi, B_WRI);
    ewdi[wi] = irw;
    sched_phase(wi + 1, r1, h1, 1'b0, 16'(IRW), res, x);
    if (res != 0) e_end = x + 1;
    else if (enw) begin
      for (int k = 1; k <= f_dr; k++) fd[x + k] = 1'b1;
      wd = x + f_dr + 1;
      add_p(wd, B_WRD);
      ewdd[wd] = drw;
      sched_phase(wd + 1, r2, h2, 1'b1, 16'(DRW), res, x2);
      if (res != 0) e_end = x2 + 1;
      else begin
        add_p(x2, cur_w ? B_DONE1 : B_DONE0);
        e_end = x2 + 2;
      end
    end else begin
      add_p(x, cur_w ? B_DONE1 : B_DONE0);
      e_end = x + 2;
    end

    for (int n = 0; n < e_end; n++) begin
      req0 = (n == 0 || hold) ? pat[0] : 1'b0;
      req1 = (n == 0 || hold) ? pat[1] : 1'b0;
      // Inputs change after the grant edge so a design that fails to capture them is exposed.
      ir0 = (n == 0) ? i0 : ~i0;  ir1 = (n == 0) ? i1 : ~i1;
      dr0 = (n == 0) ? d0 : ~d0;  dr1 = (n == 0) ? d1 : ~d1;
      dr_en0 = (n == 0) ? e0 : ~e0;  dr_en1 = (n == 0) ? e1 : ~e1;
      busy = bz.exists(n);
      full_instruction = fi.exists(n);
      full_data = fd.exists(n);
      rst = (n == rst_at);
      if (rst) busy = 1'b0;
      @(posedge clk); @(negedge clk);
      if (n == rst_at) begin
        chk("rst_outputs", all_outputs(), 64'd0);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        full_instruction = 1'b0; full_data = 1'b0;
        last_w = 1;
        return;
      end
      obs  = pulses_now();
      expv = ep.exists(n) ? ep[n] : 9'd0;
      if (obs != 9'd0 || expv != 9'd0) chk("pulses", obs, expv);
      if (ewdi.exists(n)) chk("wdata_instruction", wdata_instruction, ewdi[n]);
      if (ewdd.exists(n)) chk("wdata_data", wdata_data, ewdd[n]);
      if (elen.exists(n)) chk("len", len, elen[n]);
      if (eop.exists(n))  chk("op", op, eop[n]);
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; busy = 1'b0;
    full_instruction = 1'b0; full_data = 1'b0;
    ir0 = '0; ir1 = '0; dr0 = '0; dr1 = '0; dr_en0 = 1'b0; dr_en1 = 1'b0;
    last_w = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;

    // IR only for requester 0, then IR+DR for requester 1.
    run_seq(2'b01, 0, 10'h2A5, 10'h000, 8'h00, 8'h00, 0, 0, 0, 1, 20, 0, 1, 1, 2, -1);
    run_seq(2'b10, 0, 10'h000, 10'h0FF, 8'h00, 8'h5A, 0, 1, 0, 1, 20, 0, 1, 15, 1, -1);
    // Both held for four sequences: grants alternate starting with 0.
    for (int s = 0; s < 4; s++)
      run_seq(2'b11, 1, 10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), 0, 1, 6, 0, 1, 5, 0, -1);
    // Instruction FIFO full for 5 cycles after the grant.
    run_seq(2'b01, 0, 10'h155, 10'h0, 8'h0, 8'h0, 0, 0, 5, 1, 4, 0, 1, 1, 1, -1);
    // Busy never rises, then busy rising on the last allowed cycle.
    run_seq(2'b01, 0, 10'h3C3, 10'h0, 8'h0, 8'h0, 0, 0, 0, 99, 1, 0, 1, 1, 1, -1);
    run_seq(2'b10, 0, 10'h0, 10'h111, 8'h0, 8'h77, 0, 1, 1, RISE, 3, 2, RISE, 2, 1, -1);
    // Scan timeout boundary: busy high exactly TMO cycles is fine, one more is an error.
    run_seq(2'b01, 0, 10'h0AA, 10'h0, 8'h0, 8'h0, 0, 0, 0, 2, TMO, 0, 1, 1, 1, -1);
    run_seq(2'b10, 0, 10'h0, 10'h2DD, 8'h0, 8'h0, 0, 0, 0, 1, TMO + 1, 0, 1, 1, 1, -1);
    // Reset while in the busy window, then both request: requester 0 must win.
    run_seq(2'b01, 0, 10'h123, 10'h0, 8'h0, 8'h0, 1, 0, 0, 1, 30, 0, 1, 1, 1, 8);
    run_seq(2'b11, 0, 10'h321, 10'h0F0, 8'hA5, 8'h3C, 1, 1, 1, 2, 5, 1, 3, 4, 1, -1);

    for (int s = 0; s < 40; s++) begin
      logic [1:0] p;
      int r1, r2;
      p  = 2'($urandom_range(1, 3));
      r1 = ($urandom_range(0, 9) == 0) ? RISE + 1 : int'($urandom_range(1, RISE));
      r2 = ($urandom_range(0, 9) == 0) ? RISE + 1 : int'($urandom_range(1, RISE));
      run_seq(p, 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), r1, int'($urandom_range(1, 30)),
              int'($urandom_range(0, 3)), r2, int'($urandom_range(1, 30)),
              int'($urandom_range(0, 3)), -1);
    end

    req0 = 1'b0; req1 = 1'b0; busy = 1'b0;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
